// File: rtl/pipelined_add_sub_if.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub_if
//   Bundles the operand-side and result-side handshakes of the pipelined
//   adder/subtractor into one interface.
//
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf, zero
//
//   Modports
//     master : the user of the block (drives operands, consumes results)
//     slave  : the adder itself (consumes operands, drives results)
// ---------------------------------------------------------------------------
interface pipelined_add_sub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf,
        output zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
//   Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES
//   equal slices of W = N/STAGES bits; each pipeline stage adds one slice and
//   registers its carry for the next one. One operation per cycle can enter.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous, active-high reset (clears every valid bit and the
//            result fields; wins over any handshake in the same cycle)
//     bus  : pipelined_add_sub_if.slave
//              in_valid/in_ready/a/b/cin/sub        operand handshake
//              out_valid/out_ready/sum/cout/ovf/zero result handshake
//
//   Operation: sub=0 -> a + b + cin ; sub=1 -> a + ~b + 1 (cin ignored).
//   Latency is STAGES cycles from acceptance to out_valid.
// ---------------------------------------------------------------------------
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_add_sub_if.slave  bus
);

    localparam int W = N / STAGES;

    // Refuse to build a pipeline whose slices would not tile the operand.
    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_add_sub: N (%0d) must be a multiple of STAGES (%0d)",
               N, STAGES);
    end

    // Per-stage pipeline registers. Entry k holds the state after slice k
    // has been added: full operands (the upper, not yet consumed slices are
    // what matters downstream), partial result with slices 0..k filled in,
    // carry out of slice k and the slot's valid bit.
    logic [N-1:0] a_reg     [STAGES];
    logic [N-1:0] b_reg     [STAGES];
    logic [N-1:0] res_reg   [STAGES];
    logic         carry_reg [STAGES];
    logic         valid_reg [STAGES];

    // Flags of the last stage, registered alongside its result.
    logic ovf_reg;
    logic zero_reg;
    logic ovf_next;
    logic zero_next;
    logic msb_carry_in;

    // Global advance: the whole pipe moves unless a result is waiting
    // at the output and nobody takes it.
    logic adv;
    assign adv          = !valid_reg[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [N-1:0] a_src;
        logic [N-1:0] b_src;
        logic [N-1:0] res_src;
        logic         carry_src;
        logic         valid_src;
        logic [W:0]   slice_sum;
        logic [N-1:0] res_next;

        if (gi == 0) begin : g_src_in
            // Subtraction is folded in here: B is inverted once and the
            // "+1" enters as the carry into slice 0.
            assign a_src     = bus.a;
            assign b_src     = bus.sub ? ~bus.b : bus.b;
            assign carry_src = bus.sub | bus.cin;
            assign valid_src = bus.in_valid;
            assign res_src   = '0;
        end else begin : g_src_pipe
            assign a_src     = a_reg[gi-1];
            assign b_src     = b_reg[gi-1];
            assign carry_src = carry_reg[gi-1];
            assign valid_src = valid_reg[gi-1];
            assign res_src   = res_reg[gi-1];
        end

        assign slice_sum = {1'b0, a_src[gi*W +: W]}
                         + {1'b0, b_src[gi*W +: W]}
                         + (W+1)'(carry_src);

        always_comb begin
            res_next            = res_src;
            res_next[gi*W +: W] = slice_sum[W-1:0];
        end

        if (gi == STAGES - 1) begin : g_flags
            // Carry into the MSB recovered from the MSB sum bit:
            // s = a ^ b ^ c  =>  c = a ^ b ^ s.
            assign msb_carry_in = a_src[N-1] ^ b_src[N-1] ^ slice_sum[W-1];
            assign ovf_next     = msb_carry_in ^ slice_sum[W];
            assign zero_next    = (res_next == '0);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                carry_reg[gi] <= 1'b0;
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
                res_reg[gi]   <= '0;
            end else if (adv) begin
                valid_reg[gi] <= valid_src;
                carry_reg[gi] <= slice_sum[W];
                a_reg[gi]     <= a_src;
                b_reg[gi]     <= b_src;
                res_reg[gi]   <= res_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (adv) begin
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
        end
    end

    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.sum       = res_reg[STAGES-1];
    assign bus.cout      = carry_reg[STAGES-1];
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_add_sub
//   Directed, table-driven bench for pipelined_add_sub. A 32-bit/4-stage
//   instance carries most tests; a 64-bit/8-stage instance checks carries
//   crossing many slices. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.N(32)) bus32 ();
    pipelined_add_sub_if #(.N(64)) bus64 ();

    pipelined_add_sub #(.N(32), .STAGES(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    pipelined_add_sub #(.N(64), .STAGES(8)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs32 [10];
    vec_t vecs64 [4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: checks exact latency, all result fields and
    // that exactly one result comes out.
    task automatic run_vec(input bit wide, input vec_t v, input int idx);
        int          lat;
        logic [63:0] got_sum;
        lat = wide ? 8 : 4;
        if (wide) begin
            bus64.in_valid = 1'b1;
            bus64.a = v.a;
            bus64.b = v.b;
            bus64.cin = v.cin;
            bus64.sub = v.sub;
        end else begin
            bus32.in_valid = 1'b1;
            bus32.a = v.a[31:0];
            bus32.b = v.b[31:0];
            bus32.cin = v.cin;
            bus32.sub = v.sub;
        end
        #1;
        check("vec in_ready", wide ? bus64.in_ready : bus32.in_ready, 1);
        next_cycle();
        bus32.in_valid = 1'b0;
        bus64.in_valid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            check("vec early out_valid", wide ? bus64.out_valid : bus32.out_valid, 0);
            next_cycle();
        end
        got_sum = wide ? bus64.sum : {32'b0, bus32.sum};
        check("vec out_valid", wide ? bus64.out_valid : bus32.out_valid, 1);
        check("vec sum",  got_sum, v.sum);
        check("vec cout", wide ? bus64.cout : bus32.cout, v.cout);
        check("vec ovf",  wide ? bus64.ovf  : bus32.ovf,  v.ovf);
        check("vec zero", wide ? bus64.zero : bus32.zero, v.zero);
        $display("vec%0d w%0d: a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b zero=%0b",
                 idx, wide ? 64 : 32, v.a, v.b, v.cin, v.sub, got_sum,
                 wide ? bus64.cout : bus32.cout, wide ? bus64.ovf : bus32.ovf,
                 wide ? bus64.zero : bus32.zero);
        next_cycle();
        check("vec single result", wide ? bus64.out_valid : bus32.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int          sent;
        int          got;
        logic [31:0] held;
        logic        was_stalled;

        //                a                      b                      cin   sub   sum                    cout  ovf   zero
        vecs32[0] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0, 1'b0, 64'h00000000_00000000, 1'b1, 1'b0, 1'b1};
        vecs32[1] = '{64'h00000000_80000000, 64'h00000000_00000001, 1'b0, 1'b1, 64'h00000000_7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs32[2] = '{64'h00000000_00000001, 64'h00000000_00000002, 1'b0, 1'b1, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs32[3] = '{64'h00000000_7FFFFFFF, 64'h00000000_00000001, 1'b0, 1'b0, 64'h00000000_80000000, 1'b0, 1'b1, 1'b0};
        vecs32[4] = '{64'h00000000_12345678, 64'h00000000_11111111, 1'b1, 1'b0, 64'h00000000_2345678A, 1'b0, 1'b0, 1'b0};
        vecs32[5] = '{64'h00000000_00000005, 64'h00000000_00000005, 1'b1, 1'b1, 64'h00000000_00000000, 1'b1, 1'b0, 1'b1};
        vecs32[6] = '{64'h00000000_0000FFFF, 64'h00000000_00000000, 1'b1, 1'b0, 64'h00000000_00010000, 1'b0, 1'b0, 1'b0};
        vecs32[7] = '{64'h00000000_80000000, 64'h00000000_80000000, 1'b0, 1'b0, 64'h00000000_00000000, 1'b1, 1'b1, 1'b1};
        vecs32[8] = '{64'h00000000_00000000, 64'h00000000_00000001, 1'b0, 1'b1, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs32[9] = '{64'h00000000_FFFFFFFF, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 1'b0};

        vecs64[0] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b1, 1'b0, 64'h00000001_00000001, 1'b0, 1'b0, 1'b0};
        vecs64[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000000, 1'b1, 1'b0, 64'h00000000_00000000, 1'b1, 1'b0, 1'b1};
        vecs64[2] = '{64'h00000000_00000000, 64'h00000000_00000001, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs64[3] = '{64'h7FFFFFFF_FFFFFFFF, 64'h00000000_00000001, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0};

        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
        bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0; bus64.sub = 1'b0;
        bus64.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("reset out_valid", bus32.out_valid, 0);
        check("reset sum",       bus32.sum, 0);
        check("reset cout",      bus32.cout, 0);
        check("reset ovf",       bus32.ovf, 0);
        check("reset zero",      bus32.zero, 0);
        check("reset in_ready",  bus32.in_ready, 1);
        check("reset out_valid w64", bus64.out_valid, 0);

        // Single operations from the table
        for (int i = 0; i < 10; i++) run_vec(1'b0, vecs32[i], i);
        for (int i = 0; i < 4; i++)  run_vec(1'b1, vecs64[i], i);

        // Eight back-to-back adds i + 3*i; results at cycles 4..11
        for (int c = 0; c < 14; c++) begin
            check("b2b out_valid", bus32.out_valid, (c >= 4 && c < 12) ? 1 : 0);
            if (c >= 4 && c < 12) begin
                check("b2b sum", bus32.sum, 64'(4 * (c - 4)));
                $display("b2b cycle %0d: sum=%h", c, bus32.sum);
            end
            bus32.in_valid = (c < 8);
            bus32.a = 32'(c);
            bus32.b = 32'(3 * c);
            bus32.cin = 1'b0;
            bus32.sub = 1'b0;
            #1;
            check("b2b in_ready", bus32.in_ready, 1);
            next_cycle();
        end

        // Backpressure: out_ready low in cycles 5..7 with the pipe full
        sent = 0;
        got = 0;
        held = '0;
        was_stalled = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (was_stalled) begin
                check("stall hold valid", bus32.out_valid, 1);
                check("stall hold sum",   bus32.sum, held);
            end
            bus32.out_ready = !(c >= 5 && c <= 7);
            bus32.in_valid = (sent < 10);
            bus32.a = 32'(100 + sent);
            bus32.b = 32'(sent);
            #1;
            if (c >= 5 && c <= 7) check("stall in_ready", bus32.in_ready, 0);
            if (bus32.in_valid && bus32.in_ready) sent++;
            if (bus32.out_valid && bus32.out_ready) begin
                check("stall order sum", bus32.sum, 64'(100 + 2 * got));
                $display("stall pop %0d: sum=%h (cycle %0d)", got, bus32.sum, c);
                got++;
            end
            was_stalled = bus32.out_valid && !bus32.out_ready;
            held = bus32.sum;
            next_cycle();
            if (got == 10) break;
        end
        check("stall result count", 64'(got), 10);
        check("stall no duplicate", bus32.out_valid, 0);
        bus32.out_ready = 1'b1;

        // Reset with three operations in flight (plus one presented during reset)
        for (int c = 0; c < 4; c++) begin
            bus32.in_valid = 1'b1;
            bus32.a = 32'h0000_1000 + 32'(c);
            bus32.b = 32'h1;
            bus32.sub = 1'b1;
            rst = (c == 3);
            next_cycle();
        end
        rst = 1'b0;
        bus32.in_valid = 1'b0;
        bus32.sub = 1'b0;
        #1;
        check("midreset out_valid", bus32.out_valid, 0);
        check("midreset sum",       bus32.sum, 0);
        check("midreset cout",      bus32.cout, 0);
        check("midreset ovf",       bus32.ovf, 0);
        check("midreset zero",      bus32.zero, 0);
        check("midreset in_ready",  bus32.in_ready, 1);
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            check("midreset dropped", bus32.out_valid, 0);
        end
        $display("midreset: no result emerged after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
